generic_sync_dpram: RTL and testbench
=====================================

GENERIC_SYNC_DPRAM -- requirements
Module: generic_sync_dpram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 8, address width in bits.
REQ-003 Parameter RAM_DEPTH, default 1<<ADDR_WIDTH, number of words; SHALL satisfy RAM_DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter RDW_MODE, default 0, same-port read-during-write: 0 read-first (old data), 1 write-first (new data).
REQ-005 Parameter OUT_REG, default 0, 1 adds one output pipeline register per port.
REQ-006 Parameter INIT_ON_RESET, default 1, 1 zero-fills the array after reset.
REQ-007 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-008 clk  in  1  clock, all state on rising edge.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 a_cs / b_cs  in  1  port select.
REQ-011 a_we / b_we  in  1  write enable, qualified by cs.
REQ-012 a_be / b_be  in  DATA_WIDTH/8  byte enables for writes.
REQ-013 a_addr / b_addr  in  ADDR_WIDTH  word address.
REQ-014 a_wdata / b_wdata  in  DATA_WIDTH  write data.
REQ-015 a_rdata / b_rdata  out  DATA_WIDTH  read data.
REQ-016 a_rvalid / b_rvalid  out  1  rdata valid, one-cycle pulse per accepted access.
REQ-017 init_busy  out  1  high while the zero-fill sweep runs.

Function
REQ-018 An access on a port is accepted when cs=1 and init_busy=0; accesses while init_busy=1 SHALL be ignored, with no write and no rvalid.
REQ-019 Each accepted access, read or write, SHALL return data: rvalid and rdata appear 1+OUT_REG cycles after the accepting edge.
REQ-020 Writes SHALL update only the bytes whose be bit is 1; a be of all zeros leaves the word unchanged but still returns rvalid.
REQ-021 Same-port read-during-write SHALL return the pre-write word when RDW_MODE=0 and the post-write word (byte-merged) when RDW_MODE=1.
REQ-022 Cross-port: a read of an address the other port writes in the same cycle SHALL return the pre-write word.
REQ-023 Both ports writing the same address in the same cycle: for bytes enabled on both ports port A SHALL win; other bytes are merged.
REQ-024 Addresses >= RAM_DEPTH SHALL be ignored for writes and return rdata=0 with rvalid asserted.
REQ-025 rdata SHALL hold its last value while rvalid=0.
REQ-026 The init FSM SHALL have states INIT and READY. INIT writes zero to address 0..RAM_DEPTH-1, one word per cycle, then moves to READY. The RAM_DEPTH-cycle sweep starts at the first edge after reset release.
REQ-027 With INIT_ON_RESET=0 the FSM SHALL enter READY directly at reset release, and array contents are unspecified.
REQ-028 init_busy SHALL equal (state==INIT).

Reset
REQ-029 While rst_n=0: a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, and the output pipeline is cleared.
REQ-030 While rst_n=0: state=INIT if INIT_ON_RESET else READY, init_busy=INIT_ON_RESET, and the sweep counter=0.
REQ-031 Reset asserted mid-sweep or mid-access SHALL abort it; in-flight rvalid is dropped and the sweep restarts from address 0.
REQ-032 The memory array itself SHALL NOT be reset by rst_n; it is cleared only by the sweep.

Structure
REQ-033 The shared package nexi_mem_pkg SHALL hold the RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants and the init state encoding (INIT, READY).
REQ-034 The init sequencer (FSM plus address counter) SHALL be the single sub-module mem_init_seq.
REQ-035 The array SHALL be written so that it infers block RAM with a byte-write-enable template, with the remaining logic in the top module.

Verification
REQ-036 Reset with INIT_ON_RESET=1, RAM_DEPTH=256 -> init_busy high for exactly 256 cycles; afterwards a read of address 0xFF returns 0 with rvalid one cycle later.
REQ-037 Port A writes 0xDEADBEEF to address 5 with be=4'b0101 over 0 -> a read of address 5 returns 0x00AD00EF.
REQ-038 RDW_MODE=1: word at address 3 holds 0x11111111; port A writes 0x22222222 to address 3 with be=4'b1111 -> a_rdata=0x22222222. Same stimulus with RDW_MODE=0 -> 0x11111111. Port B reading address 3 in the same cycle gets 0x11111111.
REQ-039 Both ports write address 9 in the same cycle, A=0xAAAAAAAA be=1100, B=0xBBBBBBBB be=0110 -> address 9 holds 0xAAAABB00.
REQ-040 OUT_REG=1: back-to-back reads of addresses 1,2,3 on port B -> b_rvalid is high for 3 consecutive cycles starting 2 cycles after the first access, with data in order.
REQ-041 rst_n pulled low at sweep address 100, then released -> the sweep restarts at address 0 and takes the full 256 cycles; port A cs during the sweep gives no rvalid and no write.

Source files
------------

// File: rtl/nexi_mem_pkg.sv
// Shared constants for the dual-port memory: read-during-write modes and the
// init sequencer state encoding.
package nexi_mem_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    function automatic int bytesPerWord(input int dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Init sequencer: after reset release it sweeps addresses 0..RAM_DEPTH-1 one
// per cycle so the array can be zero-filled, then parks in READY.
module mem_init_seq
    import nexi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    init_state_e           r_state;
    init_state_e           w_stateNext;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cntNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (INIT_ON_RESET != 0) begin
                r_state <= INIT;
            end else begin
                r_state <= READY;
            end
            r_cnt <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // The last swept address moves the FSM to READY on the same edge it is written.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            INIT: begin
                if (r_cnt == LAST_ADDR) begin
                    w_stateNext = READY;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + ADDR_WIDTH'(1);
                end
            end
            READY: begin
                w_stateNext = READY;
            end
            default: begin
                w_stateNext = READY;
            end
        endcase
    end

    assign o_busy = (r_state == INIT);
    assign o_addr = r_cnt;

endmodule

// File: rtl/generic_sync_dpram.sv
// True dual-port synchronous RAM with byte enables, selectable same-port
// read-during-write behaviour, optional output register and zero-fill after reset.
module generic_sync_dpram
    import nexi_mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
    parameter int RDW_MODE      = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_cs,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_cs,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid,
    output logic                    init_busy
);

    localparam int                  NB      = bytesPerWord(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    function automatic logic [DATA_WIDTH-1:0] expandBe(input logic [NB-1:0] be);
        logic [DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

    logic                  w_initBusy;
    logic [ADDR_WIDTH-1:0] w_initAddr;

    mem_init_seq #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RAM_DEPTH    (RAM_DEPTH),
        .INIT_ON_RESET(INIT_ON_RESET)
    ) u_initSeq (
        .clk   (clk),
        .rst_n (rst_n),
        .o_busy(w_initBusy),
        .o_addr(w_initAddr)
    );

    assign init_busy = w_initBusy;

    logic w_aAcc, w_aInRange, w_aWrite;
    logic w_bAcc, w_bInRange, w_bWrite;

    assign w_aAcc     = a_cs & ~w_initBusy;
    assign w_bAcc     = b_cs & ~w_initBusy;
    assign w_aInRange = ({1'b0, a_addr} < DEPTH_L);
    assign w_bInRange = ({1'b0, b_addr} < DEPTH_L);
    assign w_aWrite   = w_aAcc & a_we & w_aInRange;
    assign w_bWrite   = w_bAcc & b_we & w_bInRange;

    logic [DATA_WIDTH-1:0] r_mem [0:RAM_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_aMemQ;
    logic [DATA_WIDTH-1:0] r_bMemQ;

    // Port B bytes are written before port A so A wins on a shared byte.
    // Reads capture the pre-write word; write-first is merged after the register.
    always_ff @(posedge clk) begin
        if (w_initBusy) begin
            r_mem[w_initAddr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (w_bWrite && b_be[i]) begin
                    r_mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
                end
                if (w_aWrite && a_be[i]) begin
                    r_mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
        if (w_aAcc && w_aInRange) begin
            r_aMemQ <= r_mem[a_addr];
        end
        if (w_bAcc && w_bInRange) begin
            r_bMemQ <= r_mem[b_addr];
        end
    end

    logic                  r_aValid1, r_aZero1;
    logic [DATA_WIDTH-1:0] r_aMask1, r_aWdata1;
    logic                  r_bValid1, r_bZero1;
    logic [DATA_WIDTH-1:0] r_bMask1, r_bWdata1;

    // r_xZero1 forces a zero result after reset and for out-of-range accesses;
    // r_xMask1 carries the port's own write bytes when write-first is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aValid1 <= 1'b0;
            r_aZero1  <= 1'b1;
            r_aMask1  <= '0;
            r_aWdata1 <= '0;
            r_bValid1 <= 1'b0;
            r_bZero1  <= 1'b1;
            r_bMask1  <= '0;
            r_bWdata1 <= '0;
        end else begin
            r_aValid1 <= w_aAcc;
            r_bValid1 <= w_bAcc;
            if (w_aAcc) begin
                r_aZero1  <= ~w_aInRange;
                r_aMask1  <= (RDW_MODE == RDW_WRITE_FIRST && a_we) ? expandBe(a_be) : '0;
                r_aWdata1 <= a_wdata;
            end
            if (w_bAcc) begin
                r_bZero1  <= ~w_bInRange;
                r_bMask1  <= (RDW_MODE == RDW_WRITE_FIRST && b_we) ? expandBe(b_be) : '0;
                r_bWdata1 <= b_wdata;
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_aData1;
    logic [DATA_WIDTH-1:0] w_bData1;

    assign w_aData1 = r_aZero1 ? '0 : ((r_aMemQ & ~r_aMask1) | (r_aWdata1 & r_aMask1));
    assign w_bData1 = r_bZero1 ? '0 : ((r_bMemQ & ~r_bMask1) | (r_bWdata1 & r_bMask1));

    generate
        if (OUT_REG != 0) begin : g_outReg
            logic                  r_aValid2, r_bValid2;
            logic [DATA_WIDTH-1:0] r_aData2, r_bData2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_aValid2 <= 1'b0;
                    r_bValid2 <= 1'b0;
                    r_aData2  <= '0;
                    r_bData2  <= '0;
                end else begin
                    r_aValid2 <= r_aValid1;
                    r_bValid2 <= r_bValid1;
                    if (r_aValid1) begin
                        r_aData2 <= w_aData1;
                    end
                    if (r_bValid1) begin
                        r_bData2 <= w_bData1;
                    end
                end
            end

            assign a_rvalid = r_aValid2;
            assign a_rdata  = r_aData2;
            assign b_rvalid = r_bValid2;
            assign b_rdata  = r_bData2;
        end else begin : g_noOutReg
            assign a_rvalid = r_aValid1;
            assign a_rdata  = w_aData1;
            assign b_rvalid = r_bValid1;
            assign b_rdata  = w_bData1;
        end
    endgenerate

endmodule

// File: tb/tb_generic_sync_dpram.sv
// Self-checking bench: two RAM configurations driven in lockstep, checked against
// a per-configuration array model plus fixed vectors and hand-written sequences.
module tb_generic_sync_dpram;

    localparam int DEPTH_OF [2] = '{256, 200};
    localparam int RDW_OF   [2] = '{0, 1};
    localparam int LAT_OF   [2] = '{1, 2};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aCs, aWe, bCs, bWe;
    logic [3:0]  aBe, bBe;
    logic [7:0]  aAddr, bAddr;
    logic [31:0] aWdata, bWdata;

    logic [31:0] a0Rdata, b0Rdata, a1Rdata, b1Rdata;
    logic        a0Rvalid, b0Rvalid, a1Rvalid, b1Rvalid;
    logic        busy0, busy1;

    always #5 clk = ~clk;

    generic_sync_dpram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(256),
        .RDW_MODE(0), .OUT_REG(0), .INIT_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_cs(aCs), .a_we(aWe), .a_be(aBe), .a_addr(aAddr), .a_wdata(aWdata),
        .a_rdata(a0Rdata), .a_rvalid(a0Rvalid),
        .b_cs(bCs), .b_we(bWe), .b_be(bBe), .b_addr(bAddr), .b_wdata(bWdata),
        .b_rdata(b0Rdata), .b_rvalid(b0Rvalid),
        .init_busy(busy0)
    );

    generic_sync_dpram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(200),
        .RDW_MODE(1), .OUT_REG(1), .INIT_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_cs(aCs), .a_we(aWe), .a_be(aBe), .a_addr(aAddr), .a_wdata(aWdata),
        .a_rdata(a1Rdata), .a_rvalid(a1Rvalid),
        .b_cs(bCs), .b_we(bWe), .b_be(bBe), .b_addr(bAddr), .b_wdata(bWdata),
        .b_rdata(b1Rdata), .b_rvalid(b1Rvalid),
        .init_busy(busy1)
    );

    typedef struct {
        logic        aCs, aWe;
        logic [3:0]  aBe;
        logic [7:0]  aAddr;
        logic [31:0] aWdata;
        logic        bCs, bWe;
        logic [3:0]  bBe;
        logic [7:0]  bAddr;
        logic [31:0] bWdata;
        logic        expAV;
        logic [31:0] expAD;
        logic        expBV;
        logic [31:0] expBD;
    } vec_t;

    logic [31:0] mdlMem [2][256];
    int          busyLeft [2];
    logic        pendV [2][2];
    logic [31:0] pendD [2][2];
    logic [31:0] heldD [2][2];
    int          nChecks = 0;
    int          nFails  = 0;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? newW[8*i +: 8] : oldW[8*i +: 8];
        end
        return r;
    endfunction

    function automatic vec_t mkVec(
        input logic aC, input logic aW, input logic [3:0] aB, input logic [7:0] aA, input logic [31:0] aD,
        input logic bC, input logic bW, input logic [3:0] bB, input logic [7:0] bA, input logic [31:0] bD,
        input logic eAV, input logic [31:0] eAD, input logic eBV, input logic [31:0] eBD);
        vec_t v;
        v.aCs = aC; v.aWe = aW; v.aBe = aB; v.aAddr = aA; v.aWdata = aD;
        v.bCs = bC; v.bWe = bW; v.bBe = bB; v.bAddr = bA; v.bWdata = bD;
        v.expAV = eAV; v.expAD = eAD; v.expBV = eBV; v.expBD = eBD;
        return v;
    endfunction

    function automatic logic getV(input int d, input int p);
        case ({d[0], p[0]})
            2'b00:   return a0Rvalid;
            2'b01:   return b0Rvalid;
            2'b10:   return a1Rvalid;
            default: return b1Rvalid;
        endcase
    endfunction

    function automatic logic [31:0] getD(input int d, input int p);
        case ({d[0], p[0]})
            2'b00:   return a0Rdata;
            2'b01:   return b0Rdata;
            2'b10:   return a1Rdata;
            default: return b1Rdata;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        aCs = v.aCs; aWe = v.aWe; aBe = v.aBe; aAddr = v.aAddr; aWdata = v.aWdata;
        bCs = v.bCs; bWe = v.bWe; bBe = v.bBe; bAddr = v.bAddr; bWdata = v.bWdata;
    endtask

    task automatic applyIdle();
        applyStimulus(mkVec(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                            1'b0, 32'h0, 1'b0, 32'h0));
    endtask

    // Advance one clock: predict results from the current inputs, then compare all outputs.
    task automatic stepCycle();
        logic        cs [2];
        logic        we [2];
        logic [3:0]  be [2];
        logic [7:0]  ad [2];
        logic [31:0] wd [2];
        logic        resV [2][2];
        logic [31:0] resD [2][2];
        cs[0] = aCs; we[0] = aWe; be[0] = aBe; ad[0] = aAddr; wd[0] = aWdata;
        cs[1] = bCs; we[1] = bWe; be[1] = bBe; ad[1] = bAddr; wd[1] = bWdata;
        for (int d = 0; d < 2; d++) begin
            logic busyNow;
            busyNow = (busyLeft[d] > 0);
            for (int p = 0; p < 2; p++) begin
                logic        inR;
                logic [31:0] oldW;
                inR        = (int'(ad[p]) < DEPTH_OF[d]);
                oldW       = inR ? mdlMem[d][ad[p]] : 32'h0;
                resV[d][p] = cs[p] && !busyNow;
                if (!inR)                          resD[d][p] = 32'h0;
                else if (RDW_OF[d] == 1 && we[p])  resD[d][p] = mergeBytes(oldW, wd[p], be[p]);
                else                               resD[d][p] = oldW;
            end
            if (busyNow) begin
                mdlMem[d][DEPTH_OF[d] - busyLeft[d]] = 32'h0;
                busyLeft[d]--;
            end else begin
                logic       wrA, wrB;
                logic [3:0] beB;
                wrA = cs[0] && we[0] && (int'(ad[0]) < DEPTH_OF[d]);
                wrB = cs[1] && we[1] && (int'(ad[1]) < DEPTH_OF[d]);
                beB = (wrA && ad[0] == ad[1]) ? (be[1] & ~be[0]) : be[1];
                if (wrA) mdlMem[d][ad[0]] = mergeBytes(mdlMem[d][ad[0]], wd[0], be[0]);
                if (wrB) mdlMem[d][ad[1]] = mergeBytes(mdlMem[d][ad[1]], wd[1], beB);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic        ev;
                logic [31:0] ed;
                if (LAT_OF[d] == 1) begin
                    ev = resV[d][p];
                    ed = resV[d][p] ? resD[d][p] : heldD[d][p];
                end else begin
                    ev = pendV[d][p];
                    ed = pendV[d][p] ? pendD[d][p] : heldD[d][p];
                    pendV[d][p] = resV[d][p];
                    pendD[d][p] = resD[d][p];
                end
                heldD[d][p] = ed;
                checkOutput($sformatf("model dut%0d port%s rvalid", d, p ? "B" : "A"),
                            {31'b0, getV(d, p)}, {31'b0, ev});
                checkOutput($sformatf("model dut%0d port%s rdata", d, p ? "B" : "A"),
                            getD(d, p), ed);
            end
        end
        checkOutput("model dut0 init_busy", {31'b0, busy0}, {31'b0, busyLeft[0] > 0});
        checkOutput("model dut1 init_busy", {31'b0, busy1}, {31'b0, busyLeft[1] > 0});
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " a0 rvalid"}, {31'b0, a0Rvalid}, 32'h0);
        checkOutput({tag, " b1 rvalid"}, {31'b0, b1Rvalid}, 32'h0);
        checkOutput({tag, " a1 rvalid"}, {31'b0, a1Rvalid}, 32'h0);
        checkOutput({tag, " a0 rdata"}, a0Rdata, 32'h0);
        checkOutput({tag, " b0 rdata"}, b0Rdata, 32'h0);
        checkOutput({tag, " a1 rdata"}, a1Rdata, 32'h0);
        checkOutput({tag, " b1 rdata"}, b1Rdata, 32'h0);
        checkOutput({tag, " busy0"}, {31'b0, busy0}, 32'h1);
        checkOutput({tag, " busy1"}, {31'b0, busy1}, 32'h1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async reset");
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("held reset");
        for (int d = 0; d < 2; d++) begin
            busyLeft[d] = DEPTH_OF[d];
            for (int p = 0; p < 2; p++) begin
                pendV[d][p] = 1'b0;
                pendD[d][p] = 32'h0;
                heldD[d][p] = 32'h0;
            end
        end
        rst_n = 1'b1;
    endtask

    // Port A issues random writes while the sweep runs; they must be ignored.
    task automatic sweepWithTraffic(input int maxCycles, output int busyCycles);
        busyCycles = 0;
        while (busy0 && busyCycles < maxCycles) begin
            applyStimulus(mkVec(1'($urandom_range(0, 1)), 1'b1, 4'hF, 8'($urandom_range(0, 255)),
                                $urandom, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
            stepCycle();
            busyCycles++;
        end
        applyIdle();
    endtask

    vec_t vecs [9];
    int   sweepLen;

    initial begin
        rst_n = 1'b1;
        applyIdle();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) mdlMem[d][i] = 32'h0;
        end

        vecs[0] = mkVec(1'b1, 1'b1, 4'b0101, 8'h05, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                        1'b1, 32'h00000000, 1'b0, 32'h0);
        vecs[1] = mkVec(1'b1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0,
                        1'b1, 32'h00AD00EF, 1'b1, 32'h00AD00EF);
        vecs[2] = mkVec(1'b1, 1'b1, 4'hF, 8'h03, 32'h11111111, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                        1'b1, 32'h00000000, 1'b0, 32'h0);
        vecs[3] = mkVec(1'b1, 1'b1, 4'hF, 8'h03, 32'h22222222, 1'b1, 1'b0, 4'h0, 8'h03, 32'h0,
                        1'b1, 32'h11111111, 1'b1, 32'h11111111);
        vecs[4] = mkVec(1'b1, 1'b1, 4'b1100, 8'h09, 32'hAAAAAAAA, 1'b1, 1'b1, 4'b0110, 8'h09, 32'hBBBBBBBB,
                        1'b1, 32'h00000000, 1'b1, 32'h00000000);
        vecs[5] = mkVec(1'b1, 1'b0, 4'h0, 8'h09, 32'h0, 1'b1, 1'b0, 4'h0, 8'h03, 32'h0,
                        1'b1, 32'hAAAABB00, 1'b1, 32'h22222222);
        vecs[6] = mkVec(1'b1, 1'b0, 4'h0, 8'hFF, 32'h0, 1'b1, 1'b1, 4'h0, 8'h00, 32'hFFFFFFFF,
                        1'b1, 32'h00000000, 1'b1, 32'h00000000);
        vecs[7] = mkVec(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 1'b0, 4'h0, 8'h09, 32'h0,
                        1'b1, 32'h00000000, 1'b1, 32'hAAAABB00);
        vecs[8] = mkVec(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                        1'b0, 32'h0, 1'b0, 32'h0);

        #2;
        doReset();

        // Abort the sweep at address 100, then the restarted sweep must take all 256 cycles.
        for (int i = 0; i < 100; i++) stepCycle();
        doReset();
        sweepWithTraffic(400, sweepLen);
        checkOutput("sweep length after mid-sweep reset", sweepLen, 32'd256);

        applyStimulus(mkVec(1'b1, 1'b0, 4'h0, 8'hFF, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                            1'b0, 32'h0, 1'b0, 32'h0));
        stepCycle();
        checkOutput("read 0xFF after sweep rvalid", {31'b0, a0Rvalid}, 32'h1);
        checkOutput("read 0xFF after sweep rdata", a0Rdata, 32'h0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput($sformatf("vec%0d A rvalid", i), {31'b0, a0Rvalid}, {31'b0, vecs[i].expAV});
            if (vecs[i].expAV) checkOutput($sformatf("vec%0d A rdata", i), a0Rdata, vecs[i].expAD);
            checkOutput($sformatf("vec%0d B rvalid", i), {31'b0, b0Rvalid}, {31'b0, vecs[i].expBV});
            if (vecs[i].expBV) checkOutput($sformatf("vec%0d B rdata", i), b0Rdata, vecs[i].expBD);
        end

        // Same-port read-during-write on both configurations, with a cross-port read.
        applyStimulus(mkVec(1'b1, 1'b1, 4'hF, 8'h03, 32'h33333333, 1'b1, 1'b0, 4'h0, 8'h03, 32'h0,
                            1'b0, 32'h0, 1'b0, 32'h0));
        stepCycle();
        checkOutput("rdw read-first A", a0Rdata, 32'h22222222);
        checkOutput("rdw cross-port B", b0Rdata, 32'h22222222);
        applyIdle();
        stepCycle();
        checkOutput("rdw write-first A rvalid", {31'b0, a1Rvalid}, 32'h1);
        checkOutput("rdw write-first A", a1Rdata, 32'h33333333);
        checkOutput("rdw write-first cross-port B", b1Rdata, 32'h22222222);

        // Back-to-back reads through the output register.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(mkVec(1'b1, 1'b1, 4'hF, 8'(k), 32'h01010101 * k, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                                1'b0, 32'h0, 1'b0, 32'h0));
            stepCycle();
        end
        for (int k = 1; k <= 5; k++) begin
            if (k <= 3) begin
                applyStimulus(mkVec(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 1'b0, 4'h0, 8'(k), 32'h0,
                                    1'b0, 32'h0, 1'b0, 32'h0));
            end else begin
                applyIdle();
            end
            stepCycle();
            checkOutput($sformatf("burst cycle%0d b1 rvalid", k), {31'b0, b1Rvalid},
                        {31'b0, (k >= 2 && k <= 4)});
            if (k >= 2) begin
                checkOutput($sformatf("burst cycle%0d b1 rdata", k), b1Rdata,
                            32'h01010101 * ((k <= 4) ? (k - 1) : 3));
            end
        end

        // Reset while a pipelined read is in flight drops it.
        applyStimulus(mkVec(1'b1, 1'b0, 4'h0, 8'h01, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                            1'b0, 32'h0, 1'b0, 32'h0));
        stepCycle();
        doReset();
        applyIdle();
        sweepWithTraffic(400, sweepLen);
        checkOutput("sweep length after in-flight reset", sweepLen, 32'd256);

        for (int n = 0; n < 2000; n++) begin
            vec_t v;
            v = mkVec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)),
                      $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)),
                      $urandom, 1'b0, 32'h0, 1'b0, 32'h0);
            applyStimulus(v);
            stepCycle();
        end
        applyIdle();
        stepCycle();
        stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
